// File: rtl/mac_package.sv
// Shared definitions for the MAC engine control channel.
// Holds the engine-facing control/flag structs, field widths, the state
// encoding of the initiator FSM and the latched job configuration struct.
package mac_package;

  localparam int MAC_CNT_LEN = 1024;
  localparam int LEN_W       = $clog2(MAC_CNT_LEN) + 1;
  localparam int SHIFT_W     = 5;
  localparam int ITER_W      = 16;

  // Fixed state codes, kept stable so older tooling that decodes the raw
  // state value keeps working.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_COMPUTE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    CLEAR   = ST_CLEAR,
    START   = ST_START,
    COMPUTE = ST_COMPUTE,
    DONE    = ST_DONE
  } mac_fsm_state_t;

  typedef struct packed {
    logic               clear;
    logic               enable;
    logic               start;
    logic               simple_mul;
    logic [SHIFT_W-1:0] shift;
    logic [LEN_W-1:0]   len;
  } ctrl_engine_t;

  typedef struct packed {
    logic [LEN_W-1:0] cnt;
    logic             acc_valid;
  } flags_engine_t;

  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [SHIFT_W-1:0] shift;
    logic               simple_mul;
    logic [ITER_W-1:0]  nb_iter;
  } ctrl_fsm_cfg_t;

endpackage

// File: rtl/mac_ctrl_fsm.sv
// Initiator side of the MAC engine control channel.
// Latches a job configuration on trigger, drives the engine control struct,
// sequences either nb_iter scalar products or one simple-multiply pass, and
// detects completion by watching handshakes on the engine output stream.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              soft clear, forces IDLE from any state
//   trigger_i            one-cycle job start request (honoured in IDLE only)
//   cfg_*_i              job configuration, latched on trigger
//   flags_i              engine flags (acc_valid only checked, cnt unused)
//   d_valid_i/d_ready_i  monitored handshake of the engine output stream
//   ctrl_o               engine control struct
//   stream_start_o       one-cycle pulse starting the input streamers
//   busy_o, done_o       job in progress / one-cycle completion event
//   iter_o               completed iterations of the current job
module mac_ctrl_fsm
  import mac_package::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               trigger_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic [SHIFT_W-1:0] cfg_shift_i,
  input  logic               cfg_simple_mul_i,
  input  logic [ITER_W-1:0]  cfg_nb_iter_i,
  input  flags_engine_t      flags_i,
  input  logic               d_valid_i,
  input  logic               d_ready_i,
  output ctrl_engine_t       ctrl_o,
  output logic               stream_start_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [ITER_W-1:0]  iter_o
);

  mac_fsm_state_t    state_reg, state_next;
  ctrl_fsm_cfg_t     cfg_reg, cfg_next;
  logic [LEN_W-1:0]  hs_cnt_reg, hs_cnt_next;
  logic [ITER_W-1:0] iter_reg, iter_next;

  logic              d_hs;
  logic [LEN_W-1:0]  hs_cnt_inc;
  logic [ITER_W-1:0] iter_inc;

  // The engine counter flag is informational only; sequencing relies on
  // the output-stream handshakes.
  logic unused_flags_cnt;
  assign unused_flags_cnt = ^flags_i.cnt;

  assign d_hs       = d_valid_i & d_ready_i;
  // Saturate at len so stray handshakes can never wrap the counter.
  assign hs_cnt_inc = (hs_cnt_reg == cfg_reg.len) ? hs_cnt_reg : hs_cnt_reg + 1'b1;
  assign iter_inc   = iter_reg + 1'b1;

  always_comb begin
    state_next  = state_reg;
    cfg_next    = cfg_reg;
    hs_cnt_next = hs_cnt_reg;
    iter_next   = iter_reg;
    if (clear_i) begin
      // Soft clear wins over trigger and handshakes; config is kept.
      state_next  = IDLE;
      hs_cnt_next = '0;
      iter_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (trigger_i) begin
            cfg_next.len        = cfg_len_i;
            cfg_next.shift      = cfg_shift_i;
            cfg_next.simple_mul = cfg_simple_mul_i;
            cfg_next.nb_iter    = (cfg_nb_iter_i == '0) ? ITER_W'(1) : cfg_nb_iter_i;
            hs_cnt_next         = '0;
            iter_next           = '0;
            state_next          = (cfg_len_i == '0) ? DONE : CLEAR;
          end
        end
        CLEAR: state_next = START;
        START: begin
          hs_cnt_next = '0;
          state_next  = COMPUTE;
        end
        COMPUTE: begin
          if (d_hs) begin
            hs_cnt_next = hs_cnt_inc;
            if (cfg_reg.simple_mul) begin
              if (hs_cnt_inc == cfg_reg.len) begin
                iter_next  = ITER_W'(1);
                state_next = DONE;
              end
            end else begin
              // One accumulated result per scalar product.
              iter_next  = iter_inc;
              state_next = (iter_inc == cfg_reg.nb_iter) ? DONE : CLEAR;
            end
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      cfg_reg    <= '0;
      hs_cnt_reg <= '0;
      iter_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cfg_reg    <= cfg_next;
      hs_cnt_reg <= hs_cnt_next;
      iter_reg   <= iter_next;
    end
  end

  always_comb begin
    ctrl_o            = '0;
    ctrl_o.clear      = clear_i | (state_reg == CLEAR);
    ctrl_o.enable     = (state_reg != IDLE);
    ctrl_o.start      = (state_reg == START);
    ctrl_o.simple_mul = cfg_reg.simple_mul;
    ctrl_o.shift      = cfg_reg.shift;
    ctrl_o.len        = cfg_reg.len;
  end

  assign stream_start_o = (state_reg == START);
  assign busy_o         = (state_reg != IDLE);
  assign done_o         = (state_reg == DONE);
  assign iter_o         = iter_reg;

  // A scalar-product result must only be emitted once the accumulator holds it.
  acc_valid_on_result: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_reg == COMPUTE && !cfg_reg.simple_mul && d_hs && !clear_i) |-> flags_i.acc_valid);

endmodule

// File: tb/tb_mac_ctrl_fsm.sv
// Self-checking bench for mac_ctrl_fsm: directed and randomized jobs
// checked against expectations derived from job-level rules.
module tb_mac_ctrl_fsm;
  import mac_package::*;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               clear_i = 1'b0;
  logic               trigger_i = 1'b0;
  logic [LEN_W-1:0]   cfg_len_i = '0;
  logic [SHIFT_W-1:0] cfg_shift_i = '0;
  logic               cfg_simple_mul_i = 1'b0;
  logic [ITER_W-1:0]  cfg_nb_iter_i = '0;
  flags_engine_t      flags_i;
  logic               d_valid_i = 1'b0;
  logic               d_ready_i = 1'b0;
  ctrl_engine_t       ctrl_o;
  logic               stream_start_o;
  logic               busy_o;
  logic               done_o;
  logic [ITER_W-1:0]  iter_o;

  int checks = 0;
  int errors = 0;

  mac_ctrl_fsm dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .clear_i          (clear_i),
    .trigger_i        (trigger_i),
    .cfg_len_i        (cfg_len_i),
    .cfg_shift_i      (cfg_shift_i),
    .cfg_simple_mul_i (cfg_simple_mul_i),
    .cfg_nb_iter_i    (cfg_nb_iter_i),
    .flags_i          (flags_i),
    .d_valid_i        (d_valid_i),
    .d_ready_i        (d_ready_i),
    .ctrl_o           (ctrl_o),
    .stream_start_o   (stream_start_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .iter_o           (iter_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // abort: 0 = run to completion, 1 = soft clear in iteration 2, 2 = reset in iteration 2
  task automatic run_job(input string name, input int len, input int shift, input bit simple,
                         input int nbi, input int stall, input int abort);
    int exp_nbi, exp_starts, exp_iter;
    int starts, pending, hs_total, last_hs, last_clear, arm_cyc, done_cnt;
    bit done_seen, aborted, valid_ok;
    logic [31:0] exp_cfg;
    exp_nbi    = (nbi == 0) ? 1 : nbi;
    exp_starts = (len == 0) ? 0 : (simple ? 1 : exp_nbi);
    exp_iter   = (len == 0) ? 0 : (simple ? 1 : exp_nbi);
    exp_cfg    = {15'd0, 1'b1, LEN_W'(len), SHIFT_W'(shift), simple};
    starts = 0; pending = 0; hs_total = 0; last_hs = -10; last_clear = -10; arm_cyc = 0;
    done_seen = 0; aborted = 0;

    check_val({name, "_idle_before"}, busy_o, 0);
    cfg_len_i        = LEN_W'(len);
    cfg_shift_i      = SHIFT_W'(shift);
    cfg_simple_mul_i = simple;
    cfg_nb_iter_i    = ITER_W'(nbi);
    trigger_i        = 1'b1;

    for (int c = 1; c <= 2000 && !done_seen && !aborted; c++) begin
      tick();
      trigger_i = 1'b0;
      d_valid_i = 1'b0;
      d_ready_i = 1'b0;
      // Config inputs wander during the job; the latched copy must not.
      cfg_len_i        = LEN_W'($urandom);
      cfg_shift_i      = SHIFT_W'($urandom);
      cfg_simple_mul_i = 1'($urandom);
      cfg_nb_iter_i    = ITER_W'($urandom);

      check_val({name, "_ctrl_cfg"}, {15'd0, ctrl_o.enable, ctrl_o.len, ctrl_o.shift, ctrl_o.simple_mul}, exp_cfg);
      if (c == 1) check_val({name, "_clear_at_t1"}, ctrl_o.clear, (len != 0));
      if (ctrl_o.clear) last_clear = c;
      if (simple && !done_o) check_val({name, "_simple_iter_zero"}, iter_o, 0);

      if (stream_start_o) begin
        starts++;
        check_val({name, "_start_flag"}, ctrl_o.start, 1);
        check_val({name, "_start_after_clear"}, last_clear, c - 1);
        if (starts == 1) check_val({name, "_first_start_t2"}, c, 2);
        else begin
          check_val({name, "_restart_latency"}, c, last_hs + 2);
          check_val({name, "_iter_progress"}, iter_o, starts - 1);
        end
        arm_cyc = c;
        pending = simple ? len : 1;
      end

      if (done_o) begin
        done_seen = 1;
        check_val({name, "_done_latency"}, c, (len == 0) ? 1 : last_hs + 1);
        check_val({name, "_start_count"}, starts, exp_starts);
        check_val({name, "_iter_final"}, iter_o, exp_iter);
      end else begin
        if (abort != 0 && starts == 2 && c == arm_cyc + 2) begin
          aborted = 1;
          if (abort == 1) begin
            clear_i = 1'b1;
            #1;
            check_val({name, "_clear_flag"}, ctrl_o.clear, 1);
            tick();
            clear_i = 1'b0;
            check_val({name, "_clear_idle"}, busy_o, 0);
            check_val({name, "_clear_iter"}, iter_o, 0);
          end else begin
            #2;
            rst_ni = 1'b0;
            #1;
            check_val({name, "_rst_ctrl"}, ctrl_o, 0);
            check_val({name, "_rst_outs"}, {busy_o, done_o, stream_start_o}, 0);
            check_val({name, "_rst_iter"}, iter_o, 0);
            tick();
            tick();
            @(negedge clk_i);
            rst_ni = 1'b1;
            tick();
            check_val({name, "_rst_idle"}, busy_o, 0);
          end
          done_cnt = 0;
          for (int k = 0; k < 12; k++) begin
            tick();
            if (done_o) done_cnt++;
          end
          check_val({name, "_no_done_after_abort"}, done_cnt, 0);
        end else begin
          if (busy_o && $urandom_range(0, 5) == 0) trigger_i = 1'b1;
          valid_ok = (pending > 0) && (c > arm_cyc) && !(abort != 0 && starts == 2);
          if (valid_ok) begin
            d_valid_i = ($urandom_range(0, 3) != 0);
            d_ready_i = (c - arm_cyc > stall) && ($urandom_range(0, 3) != 0);
            if (d_valid_i && d_ready_i) begin
              pending--;
              hs_total++;
              last_hs = c;
            end
          end
        end
      end
    end

    if (!aborted) begin
      if (!done_seen) check_val({name, "_done_timeout"}, 0, 1);
      tick();
      trigger_i = 1'b0;
      d_valid_i = 1'b0;
      d_ready_i = 1'b0;
      check_val({name, "_idle_after"}, {busy_o, done_o}, 0);
      check_val({name, "_iter_hold"}, iter_o, exp_iter);
    end
    $display("job %s: len=%0d shift=%0d simple=%0d nb_iter=%0d starts=%0d handshakes=%0d iter=%0d",
             name, len, shift, simple, nbi, starts, hs_total, iter_o);
  endtask

  initial begin
    flags_i.cnt       = '0;
    flags_i.acc_valid = 1'b1;
    #1;
    check_val("reset_ctrl", ctrl_o, 0);
    check_val("reset_outs", {busy_o, done_o, stream_start_o}, 0);
    check_val("reset_iter", iter_o, 0);
    tick();
    tick();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    check_val("idle_after_reset", busy_o, 0);

    run_job("scalar", 4, 0, 1'b0, 3, 0, 0);
    run_job("simple_stall", 5, 0, 1'b1, 1, 10, 0);
    run_job("len_zero", 0, 3, 1'b0, 2, 0, 0);
    run_job("nb_iter_zero", 4, 0, 1'b0, 0, 0, 0);
    run_job("clear_mid", 4, 0, 1'b0, 3, 0, 1);
    run_job("reset_mid", 4, 2, 1'b0, 3, 0, 2);
    run_job("integration", 4, 0, 1'b0, 1, 0, 0);

    // Clear wins over a simultaneous trigger in IDLE.
    clear_i   = 1'b1;
    trigger_i = 1'b1;
    cfg_len_i = LEN_W'(3);
    tick();
    clear_i   = 1'b0;
    trigger_i = 1'b0;
    check_val("clear_beats_trigger", busy_o, 0);

    for (int j = 0; j < 20; j++) begin
      int rlen;
      rlen = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      run_job($sformatf("rand%0d", j), rlen, int'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 3)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_ctrl_fsm.md
Name: mac_ctrl_fsm

Overview:
Initiator side of the MAC engine control channel. It latches a job configuration, drives the packed ctrl_engine_t struct (clear, enable, start, simple_mul, shift, len), sequences N scalar-product iterations or one simple-multiply pass, and watches the engine's flags and output-stream handshakes to detect completion. It sits between the register file/job trigger and the MAC engine, and issues the start pulses for the input streamers.

Parameters:
LEN_W, $clog2(MAC_CNT_LEN)+1 = 11, width of the len field and of the output-handshake counter.
SHIFT_W, 5, width of the fixed-point shift field.
ITER_W, 16, width of the iteration count.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clear_i  in  1  soft clear from register file
trigger_i  in  1  one-cycle job start request
cfg_len_i  in  LEN_W  dot-product length, or number of products in simple mode
cfg_shift_i  in  SHIFT_W  fixed-point shift
cfg_simple_mul_i  in  1  1 = simple multiply mode, 0 = scalar-product mode
cfg_nb_iter_i  in  ITER_W  number of scalar products; 0 is treated as 1
flags_i  in  flags_engine_t  engine flags {cnt, acc_valid}
d_valid_i  in  1  monitored valid of the engine output stream
d_ready_i  in  1  monitored ready of the engine output stream
ctrl_o  out  ctrl_engine_t  engine control struct
stream_start_o  out  1  one-cycle pulse that starts the input streamers
busy_o  out  1  job in progress
done_o  out  1  one-cycle job-completion event
iter_o  out  ITER_W  completed iterations

Behaviour:
- Reset values: ctrl_o = '0, stream_start_o = 0, busy_o = 0, done_o = 0, iter_o = 0, state = IDLE, all config registers 0.
- States are IDLE, CLEAR, START, COMPUTE, DONE.
- IDLE:
  - trigger_i latches cfg_*. nb_iter = max(cfg_nb_iter_i, 1).
  - If cfg_len_i == 0, go to DONE. Otherwise go to CLEAR.
- CLEAR: ctrl_o.clear = 1 for exactly one cycle, then START.
- START:
  - ctrl_o.start = 1 and stream_start_o = 1 for one cycle.
  - Zero the handshake counter, then go to COMPUTE.
- COMPUTE: a d handshake (d_valid_i & d_ready_i) increments the handshake counter.
  - Scalar mode: the first handshake ends the iteration and increments iter_o. If iter_o+1 == nb_iter, go to DONE; otherwise go to CLEAR.
  - Simple mode: the handshake that brings the count to len goes to DONE and sets iter_o = 1.
- DONE: done_o = 1 for one cycle, then IDLE. The latched config is held.
- ctrl_o field mapping:
  - enable = (state != IDLE)
  - clear = clear_i | (state == CLEAR)
  - len, shift, simple_mul = latched values, held constant for the whole job
- busy_o = (state != IDLE).
- Latency: trigger at cycle t gives CLEAR at t+1 and start/stream_start at t+2. The final d handshake at cycle k gives done_o at k+1.
- No d handshake occurs before stream_start_o. A handshake is counted only in COMPUTE; handshakes in other states are ignored.
- trigger_i outside IDLE is ignored, with no effect on state or config.
- clear_i in any state:
  - Next state is IDLE; counters and iter_o are zeroed; done_o is not asserted.
  - clear_i has priority over a simultaneous trigger_i or handshake.
- flags_i.acc_valid is used only as a check: in scalar mode, a d handshake with acc_valid = 0 is a protocol error, flagged by an assertion. flags_i.cnt is not used for sequencing.
- Counter widths: the handshake counter saturates at len. iter_o compares at ITER_W with no wrap.

Decomposition:
- mac_package holds:
  - MAC_CNT_LEN
  - ctrl_engine_t and flags_engine_t, which are shared with the engine
  - the new state enum mac_fsm_state_t
  - the new ctrl_fsm_cfg_t struct {len, shift, simple_mul, nb_iter}
- The block is a single module with no sub-module; the two counters are inline.

Test Plan:
- Reset: drive rst_ni low mid-job -> all outputs 0 on the same cycle (asynchronous); state is IDLE after release.
- Scalar mode, len=4, nb_iter=3, shift=0, d_ready=1 -> three CLEAR/START pairs; stream_start_o pulses 3 times; done_o one cycle after the 3rd d handshake; iter_o = 3.
- Simple mode, len=5, d_ready held low for 10 cycles, then high -> no progress while low; done_o after the 5th handshake; exactly one start pulse.
- clear_i asserted in COMPUTE of iteration 2 of 3 -> IDLE next cycle, ctrl_o.clear = 1 that cycle, busy_o = 0, done_o never asserted.
- Edge cases:
  - len=0 -> done_o at t+1 with no start pulse.
  - nb_iter=0 -> behaves as 1.
  - trigger_i while busy -> ignored.
- Integration with the MAC engine: a = [1,2,3,4], b = [2,2,2,2], c = 10, shift=0, nb_iter=1 -> d = 30; done_o follows the handshake.
